// File: rtl/i2s_tx.sv
// i2s_tx: 16-bit stereo I2S transmitter with a one-pair holding buffer and sticky underrun/overrun flags.
// Define I2S_TX_UNDERRUN_MUTE_EN to send silence on underrun; otherwise the last pair is repeated.
module i2s_tx #(
    parameter int SCLK_DIV = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] lft_smpl,
    input  logic [15:0] rght_smpl,
    input  logic        vld,
    input  logic        clr_err,
    output logic        rdy,
    output logic        frm_strt,
    output logic        I2S_sclk,
    output logic        I2S_ws,
    output logic        I2S_data,
    output logic        udr,
    output logic        ovr
);
    logic [7:0]  div_cnt;
    logic [5:0]  bit_cnt;
    logic [31:0] shft;
    logic [31:0] hold;
    logic [31:0] last;
    logic        full;
    logic        wrap;
    logic        fall;
    logic        load;
    logic [5:0]  nxt_p;
    logic        in_slot;
    logic [31:0] udr_pair;

    assign wrap     = div_cnt == 8'(SCLK_DIV - 1);
    assign fall     = wrap & I2S_sclk;
    assign load     = fall & (bit_cnt == 6'd63);
    assign nxt_p    = bit_cnt + 6'd1;
    // Both slots carry data at positions 1..16 of their 32-position half
    assign in_slot  = (nxt_p[4:0] != 5'd0) && (nxt_p[4:0] <= 5'd16);
    assign frm_strt = load;
    assign rdy      = ~full;
`ifdef I2S_TX_UNDERRUN_MUTE_EN
    assign udr_pair = '0;
`else
    assign udr_pair = last;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            bit_cnt  <= 6'd63;
            I2S_sclk <= 1'b0;
            I2S_ws   <= 1'b1;
            I2S_data <= 1'b0;
            shft     <= '0;
            hold     <= '0;
            last     <= '0;
            full     <= 1'b0;
            udr      <= 1'b0;
            ovr      <= 1'b0;
        end else begin
            div_cnt <= wrap ? 8'd0 : div_cnt + 8'd1;
            if (wrap)
                I2S_sclk <= ~I2S_sclk;
            if (fall) begin
                bit_cnt  <= nxt_p;
                I2S_ws   <= nxt_p[5];
                I2S_data <= in_slot ? shft[31] : 1'b0;
                if (load)
                    shft <= full ? hold : udr_pair;
                else if (in_slot)
                    shft <= {shft[30:0], 1'b0};
            end
            if (load && full)
                last <= hold;
            if (vld && (!full || load))
                hold <= {lft_smpl, rght_smpl};
            full <= vld ? 1'b1 : (load ? 1'b0 : full);
            udr  <= (load && !full) | (udr & ~clr_err);
            ovr  <= (vld && full && !load) | (ovr & ~clr_err);
        end
    end
endmodule
